axi_lite_ipif_bridge: RTL and testbench
=======================================

Name: axi_lite_ipif_bridge

Overview:
AXI4-Lite slave front end that converts AXI4-Lite register accesses from the host interconnect into the single-beat IPIF request/acknowledge protocol (Bus2IP_*/IP2Bus_*). It sits directly upstream of the pcore register file. It decodes the slave's address window and serialises reads and writes onto one IPIF channel. It also supplies a bounded timeout so that a silent slave cannot hang the AXI bus.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI and IPIF data width (32 only).
C_S_AXI_ADDR_WIDTH, 32, AXI and IPIF address width.
C_BASEADDR, 32'hFFFFFFFF, low address of the decoded window (inclusive).
C_HIGHADDR, 32'h00000000, high address of the decoded window (inclusive).
C_TIMEOUT_CYCLES, 16, number of Bus2IP_CS cycles without an ack before the bridge aborts the access (must be at least 2).

Ports:
S_AXI_ACLK  in  1  single clock for both the AXI side and the IPIF side.
S_AXI_ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  ADDR  write address.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  DATA  write data.
S_AXI_WSTRB  in  DATA/8  write byte strobes.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  ADDR  read address.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  DATA  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
Bus2IP_Clk  out  1  equal to S_AXI_ACLK.
Bus2IP_Resetn  out  1  equal to ~S_AXI_ARESET.
Bus2IP_Addr  out  ADDR  latched access address.
Bus2IP_CS  out  1  access strobe.
Bus2IP_RNW  out  1  1 = read, 0 = write.
Bus2IP_Data  out  DATA  latched write data.
Bus2IP_BE  out  DATA/8  latched WSTRB.
IP2Bus_Data  in  DATA  read data from the slave.
IP2Bus_RdAck  in  1  read acknowledge.
IP2Bus_WrAck  in  1  write acknowledge.
IP2Bus_Error  in  1  slave error, sampled together with the ack.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state:
  - All READY and VALID outputs are 0.
  - BRESP and RRESP are 00; RDATA is 0.
  - Bus2IP_CS is 0; Bus2IP_Addr, Data and BE are 0; Bus2IP_RNW is 1.
  - The FSM is in IDLE, both holding flags are clear, and last_was_write is 0.
- Write channel capture:
  - AWREADY is 1 only while in IDLE and aw_held is 0; WREADY is 1 only while in IDLE and w_held is 0.
  - A completed handshake latches the address (or data and strobe) and sets the corresponding held flag.
  - AW and W may arrive in any order or in the same cycle.
- ARREADY is 1 only in IDLE, when no write beat is partially held (aw_held or w_held set), and when the arbiter grants the read.
- Arbitration in IDLE:
  - A write is ready when both held flags are set or being set this cycle.
  - If a write and ARVALID are ready together, the write wins when last_was_write=0; otherwise the read wins.
  - last_was_write updates on each grant.
- FSM states: IDLE, DECODE, ACCESS, RESP.
  - IDLE -> DECODE on grant, with the address registered.
  - DECODE: if the address is outside [C_BASEADDR, C_HIGHADDR], go to RESP with response 11 (DECERR). Bus2IP_CS is never asserted and RDATA is 0.
  - DECODE, address in range: go to ACCESS. The registered cs_q is set and the timeout counter is cleared.
  - Bus2IP_CS = cs_q & ~(IP2Bus_RdAck | IP2Bus_WrAck), so the slave never sees CS in its ack cycle.
  - ACCESS: an ack matching RNW clears cs_q and moves to RESP. The response is 10 if IP2Bus_Error=1, else 00. For reads, RDATA is captured from IP2Bus_Data.
  - ACCESS: an ack of the wrong type is ignored.
  - ACCESS: when the counter reaches C_TIMEOUT_CYCLES-1 with no ack, clear cs_q and go to RESP with response 10; read data is 0.
  - RESP: assert BVALID or RVALID and hold BRESP/RRESP/RDATA stable until BREADY or RREADY. On that handshake, clear the held flags (writes) and return to IDLE.
- Acks arriving outside ACCESS are ignored.
- Minimum latency: AW/W handshake, then DECODE +1, CS +1, ack +1, BVALID +1.
- Reset asserted mid-operation: drop CS immediately and discard the pending response; no partial response is produced.

Test Plan:
- AW and W in the same cycle, addr C_BASEADDR+0x0C, data 0xDEADBEEF, strobe 0xF; slave acks 1 cycle after CS -> CS high exactly 1 cycle, Bus2IP_Data=0xDEADBEEF, BE=0xF, BRESP=00, one BVALID.
- W arrives 3 cycles before AW -> the write is issued only after AW; WREADY is low while w_held; data is intact.
- Read of C_HIGHADDR+4 -> Bus2IP_CS stays 0 throughout; RRESP=11; RDATA=0.
- Slave never acks, C_TIMEOUT_CYCLES=16 -> CS high for 16 cycles; BRESP=10 (write) or RRESP=10 with RDATA=0 (read).
- AW+W and AR asserted together, twice, from reset -> order is write, read, write, read; slave read data 0x12345678 is returned; RRESP=00 and 10 when IP2Bus_Error=1.
- S_AXI_ARESET pulsed during ACCESS -> CS is 0 on the next cycle; no B or R response; the next read completes normally.

Source files
------------

// File: rtl/axi_lite_ipif_bridge.sv
// rtl/axi_lite_ipif_bridge.sv - AXI4-Lite slave to single-beat IPIF bridge with window decode and access timeout
module axi_lite_ipif_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'hFFFFFFFF,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = 32'h00000000,
  parameter int C_TIMEOUT_CYCLES = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            Bus2IP_Clk,
  output logic                            Bus2IP_Resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  output logic                            Bus2IP_CS,
  output logic                            Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  input  logic                            IP2Bus_RdAck,
  input  logic                            IP2Bus_WrAck,
  input  logic                            IP2Bus_Error
);

  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} state_t;

  state_t                          state;
  logic                            aw_held, w_held, last_was_write, cs_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [CNT_W-1:0]                cnt;
  logic                            idle, aw_hs, w_hs, wr_req, rd_req, grant_wr, grant_rd;
  logic                            in_range, ack_ok, fin;
  logic [1:0]                      fin_resp;
  logic [C_S_AXI_DATA_WIDTH-1:0]   fin_data;

  assign Bus2IP_Clk    = S_AXI_ACLK;
  assign Bus2IP_Resetn = ~S_AXI_ARESET;

  // Ready outputs are combinational, so they are forced low while reset is held.
  assign idle          = (state == IDLE) & ~S_AXI_ARESET;
  assign S_AXI_AWREADY = idle & ~aw_held;
  assign S_AXI_WREADY  = idle & ~w_held;
  assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID & S_AXI_WREADY;

  // A half-captured write blocks reads so its other half can always complete.
  assign wr_req        = (aw_held | aw_hs) & (w_held | w_hs);
  assign rd_req        = S_AXI_ARVALID & ~aw_held & ~w_held;
  assign grant_wr      = idle & wr_req & (~rd_req | ~last_was_write);
  assign grant_rd      = idle & rd_req & ~grant_wr;
  assign S_AXI_ARREADY = grant_rd;

  assign in_range  = !(Bus2IP_Addr < C_BASEADDR) && !(C_HIGHADDR < Bus2IP_Addr);
  assign ack_ok    = Bus2IP_RNW ? IP2Bus_RdAck : IP2Bus_WrAck;
  assign Bus2IP_CS = cs_q & ~(IP2Bus_RdAck | IP2Bus_WrAck);

  always_comb begin
    fin      = 1'b0;
    fin_resp = 2'b00;
    fin_data = '0;
    if (state == DECODE && !in_range) begin
      fin      = 1'b1;
      fin_resp = 2'b11;
    end else if (state == ACCESS) begin
      if (ack_ok) begin
        fin      = 1'b1;
        fin_resp = IP2Bus_Error ? 2'b10 : 2'b00;
        fin_data = IP2Bus_Data;
      end else if (cnt == CNT_LAST) begin
        fin      = 1'b1;
        fin_resp = 2'b10;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state          <= IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      last_was_write <= 1'b0;
      cs_q           <= 1'b0;
      aw_addr_q      <= '0;
      cnt            <= '0;
      Bus2IP_Addr    <= '0;
      Bus2IP_Data    <= '0;
      Bus2IP_BE      <= '0;
      Bus2IP_RNW     <= 1'b1;
      S_AXI_BVALID   <= 1'b0;
      S_AXI_BRESP    <= 2'b00;
      S_AXI_RVALID   <= 1'b0;
      S_AXI_RRESP    <= 2'b00;
      S_AXI_RDATA    <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= S_AXI_AWADDR;
        aw_held   <= 1'b1;
      end
      if (w_hs) begin
        Bus2IP_Data <= S_AXI_WDATA;
        Bus2IP_BE   <= S_AXI_WSTRB;
        w_held      <= 1'b1;
      end
      if (fin) begin
        cs_q  <= 1'b0;
        state <= RESP;
        if (Bus2IP_RNW) begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RRESP  <= fin_resp;
          S_AXI_RDATA  <= fin_data;
        end else begin
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= fin_resp;
        end
      end
      case (state)
        IDLE: begin
          if (grant_wr | grant_rd) begin
            Bus2IP_Addr    <= grant_wr ? (aw_held ? aw_addr_q : S_AXI_AWADDR) : S_AXI_ARADDR;
            Bus2IP_RNW     <= grant_rd;
            last_was_write <= grant_wr;
            state          <= DECODE;
          end
        end
        DECODE: begin
          if (in_range) begin
            cs_q  <= 1'b1;
            cnt   <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!fin) cnt <= cnt + CNT_W'(1);
        end
        RESP: begin
          if (Bus2IP_RNW ? (S_AXI_RVALID & S_AXI_RREADY) : (S_AXI_BVALID & S_AXI_BREADY)) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            if (!Bus2IP_RNW) begin
              aw_held <= 1'b0;
              w_held  <= 1'b0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// tb/tb_axi_lite_ipif_bridge.sv - randomized self-checking bench for axi_lite_ipif_bridge
module tb_axi_lite_ipif_bridge;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] HIGH = 32'h0000_10FF;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        bus_clk, bus_resetn, Bus2IP_CS, Bus2IP_RNW;
  logic [31:0] Bus2IP_Addr, Bus2IP_Data, IP2Bus_Data;
  logic [3:0]  Bus2IP_BE;
  logic        IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error;

  axi_lite_ipif_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32),
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_TIMEOUT_CYCLES(TMO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .Bus2IP_Clk(bus_clk), .Bus2IP_Resetn(bus_resetn), .Bus2IP_Addr(Bus2IP_Addr),
    .Bus2IP_CS(Bus2IP_CS), .Bus2IP_RNW(Bus2IP_RNW), .Bus2IP_Data(Bus2IP_Data),
    .Bus2IP_BE(Bus2IP_BE), .IP2Bus_Data(IP2Bus_Data), .IP2Bus_RdAck(IP2Bus_RdAck),
    .IP2Bus_WrAck(IP2Bus_WrAck), .IP2Bus_Error(IP2Bus_Error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: response and visible CS cycles from the window and slave behaviour.
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input int dly, input bit err);
    if (a < BASE || a > HIGH) return 2'b11;
    if (dly > TMO - 1) return 2'b10;
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic int exp_cs(input logic [31:0] a, input int dly);
    if (a < BASE || a > HIGH) return 0;
    return (dly > TMO - 1) ? TMO : dly;
  endfunction

  // Slave: acks once it has seen CS for more than slv_delay cycles.
  int          slv_delay = 1;
  bit          slv_err_wr = 0, slv_err_rd = 0;
  logic [31:0] slv_rdata = 32'h0;
  int          cs_seen = 0;

  initial begin
    IP2Bus_RdAck = 0; IP2Bus_WrAck = 0; IP2Bus_Error = 0; IP2Bus_Data = 0;
    forever begin
      bit cs_now;
      @(posedge clk); #1;
      cs_now = Bus2IP_CS;
      IP2Bus_RdAck = 0; IP2Bus_WrAck = 0; IP2Bus_Error = 0; IP2Bus_Data = $urandom;
      if (cs_now) begin
        cs_seen++;
        if (cs_seen > slv_delay) begin
          if (Bus2IP_RNW) begin
            IP2Bus_RdAck = 1; IP2Bus_Data = slv_rdata; IP2Bus_Error = slv_err_rd;
          end else begin
            IP2Bus_WrAck = 1; IP2Bus_Error = slv_err_wr;
          end
        end
      end else begin
        cs_seen = 0;
      end
    end
  end

  int          cs_total = 0;
  bit          cs_prev = 0;
  bit          order_q[$];
  logic        cap_rnw;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    if (Bus2IP_CS) begin
      cs_total++;
      if (!cs_prev) order_q.push_back(Bus2IP_RNW);
      cap_rnw = Bus2IP_RNW; cap_addr = Bus2IP_Addr; cap_data = Bus2IP_Data; cap_be = Bus2IP_BE;
    end
    cs_prev = Bus2IP_CS;
  end

  task automatic send_aw(input logic [31:0] a);
    int cyc = 0;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1; #1;
    while (!S_AXI_AWREADY && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("aw_ready", S_AXI_AWREADY, 1);
    @(negedge clk); S_AXI_AWVALID = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int cyc = 0;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1; #1;
    while (!S_AXI_WREADY && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("w_ready", S_AXI_WREADY, 1);
    @(negedge clk); S_AXI_WVALID = 0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int cyc = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; #1;
    while (!S_AXI_ARREADY && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("ar_ready", S_AXI_ARREADY, 1);
    @(negedge clk); S_AXI_ARVALID = 0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output int lat);
    int cyc = 0;
    S_AXI_BREADY = 1;
    while (!S_AXI_BVALID && cyc < 200) begin @(negedge clk); cyc++; end
    check("bvalid_seen", S_AXI_BVALID, 1);
    resp = S_AXI_BRESP; lat = cyc;
    @(negedge clk); S_AXI_BREADY = 0;
    check("bvalid_single", S_AXI_BVALID, 0);
  endtask

  task automatic wait_r(output logic [1:0] resp, output logic [31:0] data);
    int cyc = 0;
    S_AXI_RREADY = 1;
    while (!S_AXI_RVALID && cyc < 200) begin @(negedge clk); cyc++; end
    check("rvalid_seen", S_AXI_RVALID, 1);
    resp = S_AXI_RRESP; data = S_AXI_RDATA;
    @(negedge clk); S_AXI_RREADY = 0;
    check("rvalid_single", S_AXI_RVALID, 0);
  endtask

  // order: 0 = AW and W together, 1 = AW leads by gap, 2 = W leads by gap
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap, output logic [1:0] resp, output int lat);
    fork
      begin if (order == 2) repeat (gap) @(negedge clk); send_aw(a); end
      begin if (order == 1) repeat (gap) @(negedge clk); send_w(d, s); end
    join
    wait_b(resp, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd, a, d;
    logic [3:0]  s;
    int          lat, cs0, rv, dly;
    bit          rnw, err;

    areset = 1;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_cs", Bus2IP_CS, 0);
    check("rst_rnw", Bus2IP_RNW, 1);
    check("rst_addr_data_be", Bus2IP_Addr | Bus2IP_Data | 32'(Bus2IP_BE), 0);
    check("rst_resetn", bus_resetn, 0);
    S_AXI_ARVALID = 0; areset = 0;
    @(negedge clk);

    // Write and read requested together from reset, twice.
    slv_delay = 1; slv_rdata = 32'h12345678;
    order_q.delete();
    for (int round = 0; round < 2; round++) begin
      slv_err_rd = (round == 1);
      fork
        write_txn(BASE + 8, 32'hA5A5_0000 + 32'(round), 4'hF, 0, 0, br, lat);
        begin send_ar(BASE + 16); wait_r(rr, rd); end
      join
      check("arb_bresp", br, 2'b00);
      check("arb_rresp", rr, (round == 1) ? 2'b10 : 2'b00);
      check("arb_rdata", rd, 32'h12345678);
    end
    check("arb_count", order_q.size(), 4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check("arb_order", order_q[i], (i % 2 == 1));
    slv_err_rd = 0;

    // Same-cycle AW/W, slave acks one cycle after CS.
    cs0 = cs_total;
    write_txn(BASE + 32'h0C, 32'hDEADBEEF, 4'hF, 0, 0, br, lat);
    check("w1_bresp", br, 2'b00);
    check("w1_latency", lat, 3);
    check("w1_cs_cycles", cs_total - cs0, 1);
    check("w1_data", cap_data, 32'hDEADBEEF);
    check("w1_be", cap_be, 4'hF);
    check("w1_addr", cap_addr, BASE + 32'h0C);

    // W leads AW by three cycles.
    cs0 = cs_total;
    send_w(32'hCAFEF00D, 4'h5);
    repeat (3) begin
      check("wfirst_wready_low", S_AXI_WREADY, 0);
      check("wfirst_no_cs", cs_total - cs0, 0);
      @(negedge clk);
    end
    send_aw(BASE + 32'h20);
    wait_b(br, lat);
    check("wfirst_bresp", br, 2'b00);
    check("wfirst_data", cap_data, 32'hCAFEF00D);
    check("wfirst_be", cap_be, 4'h5);
    check("wfirst_addr", cap_addr, BASE + 32'h20);

    // Read just above the window.
    cs0 = cs_total;
    send_ar(HIGH + 4); wait_r(rr, rd);
    check("dec_cs", cs_total - cs0, 0);
    check("dec_rresp", rr, 2'b11);
    check("dec_rdata", rd, 0);

    // Silent slave: write then read time out.
    slv_delay = 1000;
    cs0 = cs_total;
    write_txn(BASE + 4, 32'h1111_2222, 4'h3, 0, 0, br, lat);
    check("tmo_w_cs", cs_total - cs0, TMO);
    check("tmo_bresp", br, 2'b10);
    cs0 = cs_total;
    send_ar(BASE + 4); wait_r(rr, rd);
    check("tmo_r_cs", cs_total - cs0, TMO);
    check("tmo_rresp", rr, 2'b10);
    check("tmo_rdata", rd, 0);

    // Reset pulse during ACCESS.
    send_ar(BASE + 32'h40);
    rv = 0;
    while (!Bus2IP_CS && rv < 50) begin @(negedge clk); rv++; end
    check("rst_mid_cs_seen", Bus2IP_CS, 1);
    areset = 1;
    @(negedge clk);
    check("rst_mid_cs_drop", Bus2IP_CS, 0);
    areset = 0;
    S_AXI_RREADY = 1; S_AXI_BREADY = 1; rv = 0;
    repeat (20) begin @(negedge clk); if (S_AXI_RVALID || S_AXI_BVALID) rv++; end
    check("rst_mid_no_resp", rv, 0);
    S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    slv_delay = 2; slv_rdata = 32'h0BAD_F00D;
    send_ar(BASE + 32'h44); wait_r(rr, rd);
    check("rst_mid_next_rresp", rr, 2'b00);
    check("rst_mid_next_rdata", rd, 32'h0BAD_F00D);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      rnw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 3) a = BASE + 32'($urandom_range(0, 63) * 4);
      else if ($urandom_range(0, 1) == 1) a = HIGH + 1 + 32'($urandom_range(0, 15) * 4);
      else a = BASE - 4 - 32'($urandom_range(0, 15) * 4);
      dly = $urandom_range(1, 18);
      err = 1'($urandom_range(0, 1));
      d = $urandom; s = 4'($urandom_range(0, 15));
      slv_delay = dly; slv_err_wr = err; slv_err_rd = err; slv_rdata = $urandom;
      cs0 = cs_total;
      if (rnw) begin
        send_ar(a); wait_r(rr, rd);
        check("rnd_rresp", rr, exp_resp(a, dly, err));
        check("rnd_rdata", rd, (exp_resp(a, dly, err) != 2'b11 && dly <= TMO - 1) ? slv_rdata : 32'h0);
      end else begin
        write_txn(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), br, lat);
        check("rnd_bresp", br, exp_resp(a, dly, err));
      end
      check("rnd_cs_cycles", cs_total - cs0, exp_cs(a, dly));
      if (exp_cs(a, dly) != 0) begin
        check("rnd_addr", cap_addr, a);
        check("rnd_rnw", cap_rnw, rnw);
        if (!rnw) begin
          check("rnd_wdata", cap_data, d);
          check("rnd_be", cap_be, s);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
